// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter (CPU IO window + tube DMA).
package ram_arb_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 32;

  localparam logic [3:0] BE_FULL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READ     = 2'd1,
    RMW_READ = 2'd2,
    WRITE    = 2'd3
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_t;

endpackage

// File: rtl/ram_rr_arbiter2.sv
// Two-way round-robin grant; last_grant only advances when a grant is actually issued (en high).
module ram_rr_arbiter2
  import ram_arb_pkg::*;
#(
  parameter bit CPU_TIE_FIRST = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_cpu,
  input  logic req_dma,
  output logic grant_valid,
  output logic grant_id
);

  req_id_t last_grant_reg;
  req_id_t pick;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    pick = REQ_CPU;
    if (req_cpu && req_dma) begin
      pick = (last_grant_reg == REQ_CPU) ? REQ_DMA : REQ_CPU;
    end else if (req_dma) begin
      pick = REQ_DMA;
    end
  end

  assign grant_valid = en & (req_cpu | req_dma);
  assign grant_id    = pick;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= CPU_TIE_FIRST ? REQ_DMA : REQ_CPU;
    end else if (grant_valid) begin
      last_grant_reg <= pick;
    end
  end

endmodule

// File: rtl/ram_arbiter_32016.sv
// Shares one 512Kx32 SRAM between the 32016 CPU IO window and the tube DMA port.
// Optional RAM_EARLY_WACK_EN: write completion is acknowledged one cycle before the write phase ends.
module ram_arbiter_32016
  import ram_arb_pkg::*;
#(
  parameter int LATENCY       = 1,
  parameter bit CPU_TIE_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [18:0] cpu_addr,
  input  logic [3:0]  cpu_be,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [18:0] dma_addr,
  input  logic [3:0]  dma_be,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_ack,
  output logic        ram_cs,
  output logic        ram_oe,
  output logic        ram_wr,
  output logic        ram_ub_b,
  output logic        ram_lb_b,
  output logic [18:0] ram_addr,
  output logic [31:0] ram_dout,
  output logic        ram_doe,
  input  logic [31:0] ram_din
);

  localparam logic [2:0] LAT_CNT = 3'(LATENCY);

  state_t              state_reg;
  logic [2:0]          lcount_reg;
  req_id_t             gid_reg;
  logic [3:0]          be_reg;
  logic [DATA_W-1:0]   wdata_reg;

  logic                cpu_pend;
  logic                dma_pend;
  logic                grant_valid;
  logic                grant_raw;
  req_id_t             grant_id;
  logic                sel_wr;
  logic [3:0]          sel_be;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [DATA_W-1:0]   merged;
  logic                ack_fire;
  req_id_t             ack_id;

  // A requester whose ready is high this cycle is still holding its old request.
  assign cpu_pend = (cpu_rd | cpu_wr) & ~cpu_ready;
  assign dma_pend = dma_req & ~dma_ack;

  ram_rr_arbiter2 #(
    .CPU_TIE_FIRST(CPU_TIE_FIRST)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .en          (state_reg == IDLE),
    .req_cpu     (cpu_pend),
    .req_dma     (dma_pend),
    .grant_valid (grant_valid),
    .grant_id    (grant_raw)
  );

  assign grant_id = req_id_t'(grant_raw);

  // cpu_rd together with cpu_wr is resolved as a read.
  always_comb begin
    if (grant_id == REQ_CPU) begin
      sel_wr    = cpu_wr & ~cpu_rd;
      sel_be    = cpu_be;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
    end else begin
      sel_wr    = dma_wr;
      sel_be    = dma_be;
      sel_addr  = dma_addr;
      sel_wdata = dma_wdata;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign merged[gi*8 +: 8] = be_reg[gi] ? wdata_reg[gi*8 +: 8] : ram_din[gi*8 +: 8];
  end

  always_comb begin
    ack_fire = 1'b0;
    ack_id   = gid_reg;
    case (state_reg)
      IDLE: begin
        ack_id = grant_id;
        if (grant_valid && sel_wr) begin
          if (sel_be == 4'b0000) ack_fire = 1'b1;
`ifdef RAM_EARLY_WACK_EN
          else if (sel_be == BE_FULL && LATENCY == 0) ack_fire = 1'b1;
`endif
        end
      end
      READ: ack_fire = (lcount_reg == 3'd0);
`ifdef RAM_EARLY_WACK_EN
      RMW_READ: ack_fire = (lcount_reg == 3'd0) && (LATENCY == 0);
      WRITE:    ack_fire = (lcount_reg == 3'd1);
`else
      RMW_READ: ack_fire = 1'b0;
      WRITE:    ack_fire = (lcount_reg == 3'd0);
`endif
      default:  ack_fire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      lcount_reg <= 3'd0;
      gid_reg    <= REQ_CPU;
      be_reg     <= 4'b0000;
      wdata_reg  <= '0;
      ram_cs     <= 1'b1;
      ram_oe     <= 1'b1;
      ram_wr     <= 1'b1;
      ram_ub_b   <= 1'b1;
      ram_lb_b   <= 1'b1;
      ram_addr   <= '0;
      ram_dout   <= '0;
      ram_doe    <= 1'b0;
      cpu_ready  <= 1'b0;
      dma_ack    <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      cpu_ready <= ack_fire && (ack_id == REQ_CPU);
      dma_ack   <= ack_fire && (ack_id == REQ_DMA);
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            gid_reg    <= grant_id;
            be_reg     <= sel_be;
            wdata_reg  <= sel_wdata;
            lcount_reg <= LAT_CNT;
            // An all-zero byte-enable write touches no SRAM pins at all.
            if (!sel_wr || sel_be != 4'b0000) begin
              ram_cs   <= 1'b0;
              ram_ub_b <= 1'b0;
              ram_lb_b <= 1'b0;
              ram_addr <= sel_addr;
            end
            if (!sel_wr) begin
              ram_oe    <= 1'b0;
              state_reg <= READ;
            end else if (sel_be == BE_FULL) begin
              ram_wr    <= 1'b0;
              ram_dout  <= sel_wdata;
              ram_doe   <= 1'b1;
              state_reg <= WRITE;
            end else if (sel_be != 4'b0000) begin
              ram_oe    <= 1'b0;
              state_reg <= RMW_READ;
            end
          end
        end
        READ: begin
          if (lcount_reg != 3'd0) begin
            lcount_reg <= lcount_reg - 3'd1;
          end else begin
            if (gid_reg == REQ_CPU) cpu_rdata <= ram_din;
            else                    dma_rdata <= ram_din;
            ram_cs    <= 1'b1;
            ram_oe    <= 1'b1;
            ram_wr    <= 1'b1;
            ram_ub_b  <= 1'b1;
            ram_lb_b  <= 1'b1;
            ram_doe   <= 1'b0;
            state_reg <= IDLE;
          end
        end
        RMW_READ: begin
          if (lcount_reg != 3'd0) begin
            lcount_reg <= lcount_reg - 3'd1;
          end else begin
            // Output enable drops in the same edge the pad driver turns on, so they never overlap.
            ram_oe     <= 1'b1;
            ram_wr     <= 1'b0;
            ram_dout   <= merged;
            ram_doe    <= 1'b1;
            lcount_reg <= LAT_CNT;
            state_reg  <= WRITE;
          end
        end
        WRITE: begin
          if (lcount_reg != 3'd0) begin
            lcount_reg <= lcount_reg - 3'd1;
          end else begin
            ram_cs    <= 1'b1;
            ram_oe    <= 1'b1;
            ram_wr    <= 1'b1;
            ram_ub_b  <= 1'b1;
            ram_lb_b  <= 1'b1;
            ram_doe   <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
